gost89_cfb_ctrl: RTL

- CFB-mode stream controller that sits directly upstream of the GOST 28147-89 ECB encrypt core and drives its load/busy interface.
- Accepts 64-bit data blocks over a valid/ready handshake and XORs each with the gamma E(feedback) produced by the core.
- Emits result blocks over valid/ready.
- Launches the next core run on the new feedback as soon as it is known, so gamma generation overlaps with waiting for input. Key and sbox wire straight to the core and do not pass through this block.

---
 rtl/gost89_cfb_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/gost89_cfb_ctrl.sv
// CFB stream controller in front of a GOST 28147-89 ECB encrypt core: XORs blocks with gamma = E(fb).
// Latency: block handshaken at T is out_valid at T+1; next in_ready after core_load (T+1) plus core run.
// Backpressure: single output register; in_ready only when the slot is free or being drained this cycle.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset (forwarded as core_reset)
//   decrypt                  0: feedback = output block, 1: feedback = input block
//   iv_load, iv              restart the chain from iv (any state)
//   in_valid/in_ready/in_data     64-bit input block handshake
//   out_valid/out_ready/out_data  64-bit result block handshake
//   core_reset, core_load, core_in, core_out, core_busy   ECB core interface
//   err                      sticky core-hang timeout flag
//   blk_cnt                  blocks emitted since reset or iv_load
module gost89_cfb_ctrl #(
  parameter int MAX_WAIT = 63,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             decrypt,
  input  logic             iv_load,
  input  logic [63:0]      iv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             core_reset,
  output logic             core_load,
  output logic [63:0]      core_in,
  input  logic [63:0]      core_out,
  input  logic             core_busy,
  output logic             err,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_NOIV,
    S_LOAD,
    S_RUN,
    S_READY
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic [63:0]       fb;
  logic [63:0]       gamma;
  logic              gamma_cap;
  logic              timeout;
  logic              hs;
  logic [63:0]       xored;

  assign core_reset = reset;
  assign core_in    = fb;
  assign hs         = in_valid && in_ready;
  assign xored      = in_data ^ gamma;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    core_load    = 1'b0;
    in_ready     = 1'b0;
    gamma_cap    = 1'b0;
    timeout      = 1'b0;
    case (state)
      S_NOIV: begin
        state_nxt = S_NOIV;
      end
      S_LOAD: begin
        core_load    = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = S_RUN;
      end
      S_RUN: begin
        // First cycle in S_RUN (wait_cnt==0) ignores busy: the core may
        // register busy one cycle after the load pulse.
        if (wait_cnt != '0 && !core_busy) begin
          gamma_cap = 1'b1;
          state_nxt = S_READY;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout   = 1'b1;
          state_nxt = S_NOIV;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      S_READY: begin
        // iv_load takes precedence, so no block may be accepted that cycle.
        in_ready = (!out_valid || out_ready) && !iv_load;
        if (in_valid && in_ready) begin
          state_nxt = S_LOAD;
        end
      end
      default: begin
        state_nxt = S_NOIV;
      end
    endcase
    if (iv_load) begin
      state_nxt = S_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_NOIV;
      wait_cnt  <= '0;
      fb        <= '0;
      gamma     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      blk_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;

      if (iv_load) begin
        fb      <= iv;
        gamma   <= '0;
        err     <= 1'b0;
        blk_cnt <= '0;
      end else begin
        if (gamma_cap) begin
          gamma <= core_out;
        end
        if (timeout) begin
          err <= 1'b1;
        end
        if (hs) begin
          fb      <= decrypt ? in_data : xored;
          blk_cnt <= blk_cnt + CNT_W'(1);
        end
      end

      // Output slot survives iv_load; a write in the same cycle as a
      // consume keeps it valid with the new block.
      if (hs) begin
        out_data  <= xored;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
